// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data memory responder:
//   - default storage depth and wait-state count
//   - wait counter width
//   - FSM state enumeration (IDLE / WAIT / RESP)
//   - byte_mask(): expands a 4-bit byte enable into a 32-bit lane mask
// -----------------------------------------------------------------------------
package dmem_pkg;

  localparam int DEF_DEPTH_WORDS = 256;
  localparam int DEF_WAIT_CYCLES = 2;
  localparam int CNT_W           = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic logic [31:0] byte_mask(input logic [3:0] be);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) begin
      m[8*i +: 8] = {8{be[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// -----------------------------------------------------------------------------
// dmem_array
// Word-organised storage, one 32-bit word per index.
// Write is synchronous with per-byte enables; read is combinational.
// Ports:
//   clk    - clock
//   wr_en  - write strobe (sampled on the rising edge)
//   idx    - word index shared by the read and write paths
//   wdata  - write data
//   be     - byte enables, bit n covers wdata[8n+7:8n]
//   rdata  - word currently stored at idx
// -----------------------------------------------------------------------------
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  input  logic [3:0]    be,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] mask;

  assign mask  = byte_mask(be);
  assign rdata = mem[idx];

  // NOTE: the storage array has no reset branch; contents survive rst_n and
  // leaving it out lets synthesis map the array onto RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[idx] <= (mem[idx] & ~mask) | (wdata & mask);
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
// Single-outstanding memory responder: accepts one request while idle,
// inserts WAIT_CYCLES wait states, then pulses ack for one cycle.
// Ports:
//   clk    - clock, rising edge
//   rst_n  - synchronous active-low reset
//   req    - access request (accepted when ready=1)
//   we     - 1 = write, 0 = read
//   addr   - byte address
//   wdata  - write data
//   be     - byte enables
//   ready  - high only in IDLE (and out of reset)
//   ack    - one-cycle completion pulse
//   rdata  - read data, valid with ack on a read, held otherwise
//   err    - access error, valid with ack
// Build option: define DMEM_ERR_CHECK_EN to flag misaligned or out-of-range
// addresses (write suppressed, read returns 0). Without it err is 0 and the
// word index wraps modulo DEPTH_WORDS.
// -----------------------------------------------------------------------------
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic        ready,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] WAIT = ST_WAIT;
  localparam logic [1:0] RESP = ST_RESP;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;

  // Request fields captured at accept; stable for the whole access.
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;

  logic [31:0] rdata_hold;
  logic [31:0] mem_word;
  logic [31:0] read_value;
  logic        addr_err;
  logic        in_resp;

`ifdef DMEM_ERR_CHECK_EN
  assign addr_err = (addr_q[1:0] != 2'b00) || ((addr_q >> (AW + 2)) != 32'd0);
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr_q[1:0], addr_q[31:AW+2]};
  assign addr_err = 1'b0;
`endif

  assign in_resp = (state == RESP);
  assign ready   = rst_n && (state == IDLE);
  // Gating with rst_n keeps an access aborted by reset from acknowledging.
  assign ack     = rst_n && in_resp;
  assign err     = ack && addr_err;

  assign read_value = addr_err ? 32'd0 : mem_word;

  // NOTE: every signal written in always_comb gets a value on every path
  // (here via the first assignment) so no latch is inferred.
  always_comb begin
    rdata = rdata_hold;
    if (in_resp && !we_q) begin
      rdata = read_value;
    end
  end

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk   (clk),
    .wr_en (ack && we_q && !addr_err),
    .idx   (addr_q[AW+1:2]),
    .wdata (wdata_q),
    .be    (be_q),
    .rdata (mem_word)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      rdata_hold <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            we_q    <= we;
            addr_q  <= addr;
            wdata_q <= wdata;
            be_q    <= be;
            cnt     <= CNT_W'(WAIT_CYCLES);
            state   <= (WAIT_CYCLES == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (cnt == CNT_W'(1)) begin
            cnt   <= '0;
            state <= RESP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RESP: begin
          state <= IDLE;
          if (!we_q) begin
            rdata_hold <= read_value;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_data_mem_responder
// Self-checking bench for data_mem_responder with randomized traffic against
// a word-array reference model. Honors DMEM_ERR_CHECK_EN when defined.
// -----------------------------------------------------------------------------
module tb_data_mem_responder;

  localparam int DEPTH = 256;
  localparam int WC    = 2;
`ifdef DMEM_ERR_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        req   = 1'b0;
  logic        we    = 1'b0;
  logic [31:0] addr  = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  be    = '0;
  logic        ready;
  logic        ack;
  logic        err;
  logic [31:0] rdata;

  int checks   = 0;
  int errors   = 0;
  int ack_cnt  = 0;
  int ops_done = 0;

  logic [31:0] model [DEPTH];
  logic [31:0] last_rd = '0;

  data_mem_responder #(
    .DEPTH_WORDS(DEPTH),
    .WAIT_CYCLES(WC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .be    (be),
    .ready (ready),
    .ack   (ack),
    .rdata (rdata),
    .err   (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ack === 1'b1) ack_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: byte address -> word slot, error rule by arithmetic.
  function automatic int widx(input logic [31:0] a);
    return int'((a / 4) % DEPTH);
  endfunction

  function automatic logic bad_addr(input logic [31:0] a);
    return ERR_EN && ((a % 4 != 0) || (a >= 32'(DEPTH * 4)));
  endfunction

  // One complete access with full checking; model updated afterwards.
  task automatic run_op(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] b, input bit poke,
                        output logic [31:0] rd_out, output logic err_out);
    int          n;
    logic        exp_err;
    logic [31:0] exp_rd;
    exp_err = bad_addr(a);
    exp_rd  = exp_err ? 32'd0 : model[widx(a)];
    n = 0;
    while (ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_req", {31'd0, ready}, 32'd1);
    req = 1'b1; we = w; addr = a; wdata = d; be = b;
    @(posedge clk);
    @(negedge clk);
    // Scramble inputs: captured fields must not follow them.
    req   = poke;
    we    = 1'b1;
    addr  = a ^ 32'h40;
    wdata = $urandom;
    be    = 4'hF;
    check("ready_busy", {31'd0, ready}, 32'd0);
    n = 0;
    while (ack !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    req = 1'b0;
    check("ack_seen", {31'd0, ack}, 32'd1);
    check("latency_edges", 32'(n + 1), 32'(WC + 1));
    check("err", {31'd0, err}, {31'd0, exp_err});
    if (w) check("rdata_hold_on_write", rdata, last_rd);
    else   check("rdata_read", rdata, exp_rd);
    rd_out  = rdata;
    err_out = err;
    @(negedge clk);
    check("ack_one_cycle", {31'd0, ack}, 32'd0);
    check("ready_after", {31'd0, ready}, 32'd1);
    ops_done++;
    if (w && !exp_err) begin
      for (int i = 0; i < 4; i++)
        if (b[i]) model[widx(a)][8*i +: 8] = d[8*i +: 8];
    end
    if (!w) last_rd = exp_rd;
  endtask

  initial begin
    logic [31:0] rd;
    logic        e;
    logic [31:0] a;
    logic [3:0]  b;

    // Reset held for 3 cycles.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_ready", {31'd0, ready}, 32'd0);
      check("rst_ack", {31'd0, ack}, 32'd0);
      check("rst_rdata", rdata, 32'd0);
    end
    rst_n = 1'b1;
    #1;
    check("ready_after_release", {31'd0, ready}, 32'd1);

    // Put every word into a known state.
    for (int i = 0; i < DEPTH; i++) run_op(1'b1, 32'(i * 4), $urandom, 4'hF, 1'b0, rd, e);

    // Latency and basic write/read.
    run_op(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, rd, e);
    run_op(1'b0, 32'h10, 32'h0, 4'h0, 1'b0, rd, e);
    check("read_deadbeef", rd, 32'hDEADBEEF);

    // Byte enables, including an all-zero no-op.
    run_op(1'b1, 32'h20, 32'h11223344, 4'hF, 1'b0, rd, e);
    run_op(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 1'b0, rd, e);
    run_op(1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, 1'b0, rd, e);
    run_op(1'b0, 32'h20, 32'h0, 4'h0, 1'b0, rd, e);
    check("read_byte_merge", rd, 32'h11BB33DD);

    // Busy: a second request held during WAIT is ignored.
    run_op(1'b1, 32'h100, 32'hCAFEF00D, 4'hF, 1'b1, rd, e);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("no_extra_ack", {31'd0, ack}, 32'd0);
    end
    run_op(1'b0, 32'h140, 32'h0, 4'h0, 1'b0, rd, e);
    run_op(1'b0, 32'h100, 32'h0, 4'h0, 1'b0, rd, e);
    check("busy_first_write", rd, 32'hCAFEF00D);

    // Abort: reset during WAIT of a write.
    run_op(1'b1, 32'h30, 32'h5, 4'hF, 1'b0, rd, e);
    req = 1'b1; we = 1'b1; addr = 32'h30; wdata = 32'h99; be = 4'hF;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    rst_n = 1'b0;
    check("abort_ready_low", {31'd0, ready}, 32'd0);
    @(negedge clk);
    check("abort_rdata_zero", rdata, 32'd0);
    rst_n = 1'b1;
    last_rd = '0;
    for (int i = 0; i < 4; i++) begin
      check("abort_no_ack", {31'd0, ack}, 32'd0);
      @(negedge clk);
    end
    run_op(1'b0, 32'h30, 32'h0, 4'h0, 1'b0, rd, e);
    check("abort_kept_old", rd, 32'h5);

    // Address handling beyond the index range.
    if (ERR_EN) begin
      run_op(1'b1, 32'h402, 32'h77, 4'hF, 1'b0, rd, e);
      check("err_misaligned", {31'd0, e}, 32'd1);
      run_op(1'b1, 32'h400, 32'h66, 4'hF, 1'b0, rd, e);
      check("err_out_of_range", {31'd0, e}, 32'd1);
    end else begin
      run_op(1'b1, 32'h400, 32'h77, 4'hF, 1'b0, rd, e);
      run_op(1'b0, 32'h000, 32'h0, 4'h0, 1'b0, rd, e);
      check("wrap_read", rd, 32'h77);
    end

    // Randomized traffic.
    for (int i = 0; i < 200; i++) begin
      if (ERR_EN && $urandom_range(0, 7) != 0) a = 32'($urandom_range(0, DEPTH - 1)) * 4;
      else if (ERR_EN) a = $urandom_range(0, DEPTH * 8);
      else a = $urandom;
      b = 4'($urandom);
      run_op(1'($urandom), a, $urandom, b, ($urandom_range(0, 7) == 0), rd, e);
    end

    @(negedge clk);
    #1;
    check("ack_total", 32'(ack_cnt), 32'(ops_done));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
